fp_mul_arbiter: RTL and testbench
=================================

FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 SHALL have parameter P, default 32, meaning operand/result width (IEEE-754 single).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester i presents an operand pair.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  requester i operands accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  P  operand pairs.
REQ-007 SHALL have ports res0_valid / res1_valid  output  1  result for requester i available.
REQ-008 SHALL have ports res0_ready / res1_ready  input  1  requester i consumes the result.
REQ-009 SHALL have port res_data  output  P  registered product, shared by both requesters.
REQ-010 SHALL have ports mul_a, mul_b  output  P  registered operands to the shared combinational FP multiplier.
REQ-011 SHALL have port mul_p  input  P  product returned by the shared multiplier.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-013 IDLE: if any req_valid, SHALL grant one requester, assert only its req_ready combinationally that cycle, latch its a/b into mul_a/mul_b and its id into owner at the edge, and go to BUSY.
REQ-014 IDLE with no req_valid SHALL remain IDLE; both req_ready low.
REQ-015 Arbitration SHALL be round-robin: pointer rr (reset 0) names the favoured requester; on grant, rr becomes the non-granted id.
REQ-016 If only one requester is valid it SHALL be granted regardless of rr.
REQ-017 BUSY SHALL last exactly one cycle; at its closing edge mul_p SHALL be registered into res_data, then go to DONE.
REQ-018 DONE SHALL assert res<owner>_valid only; the other res_valid SHALL stay low.
REQ-019 DONE with res<owner>_ready high SHALL return to IDLE at the edge; res_valid deasserts the following cycle.
REQ-020 DONE with res<owner>_ready low SHALL hold state, res_data and res_valid unchanged (no timeout).
REQ-021 req_ready SHALL be low in BUSY and DONE; new requests wait, with no queue.
REQ-022 Latency: accept edge k -> res_valid high from cycle after edge k+1; minimum throughput one op per 3 cycles.
REQ-023 mul_a/mul_b SHALL hold their value from accept until the next accept.
REQ-024 res_ready of the non-owner SHALL be ignored; res_ready in IDLE/BUSY SHALL be ignored.
REQ-025 req_valid dropped before grant SHALL leave no effect; request data SHALL be sampled only at the grant edge.
REQ-026 Block SHALL not inspect or modify product bits; arithmetic is the multiplier's.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, rr=0, owner=0, mul_a=mul_b=0, res_data=0, all req_ready and res_valid 0.
REQ-028 Reset asserted in BUSY or DONE SHALL discard the in-flight operation; no result delivered after release.
REQ-029 First grant after reset release with both valid SHALL go to requester 0.

Verification
REQ-030 Single op: req0 a=0x40000000, b=0x40400000 (2.0*3.0), res0_ready=1 -> req0_ready 1 cycle, res0_valid two cycles after accept, res_data=0x40C00000, res1_valid stays 0.
REQ-031 Contention: both valid continuously, req0 1.5*1.5 (0x3FC00000 each), req1 -2.0*0.5 (0xC0000000, 0x3F000000) -> grants alternate 0,1,0,1; res_data 0x40100000 for req0, 0xBF800000 for req1.
REQ-032 Backpressure: res1_ready held low 10 cycles in DONE -> res1_valid, res_data stable, req0_ready stays 0 although req0_valid high; grant to req0 in cycle after consumption.
REQ-033 Reset mid-op: assert rst_n low during BUSY -> all outputs 0 asynchronously, no res_valid after release, next grant to requester 0.
REQ-034 Lone requester: only req1_valid with rr=0 -> req1 granted immediately; rr becomes 0.
REQ-035 Wrong-owner ready: owner 0 in DONE, res1_ready=1, res0_ready=0 -> stays DONE, res0_valid held.

Source files
------------

// File: rtl/fp_mul_arbiter_if.sv
// Handshake bundle between two requesters, the fp_mul_arbiter and the
// shared combinational FP multiplier.
//   req{0,1}_valid/_ready/_a/_b : operand request channels
//   res{0,1}_valid/_ready       : per-requester result channels
//   res_data                    : shared registered product
//   mul_a/mul_b/mul_p           : operands out to / product back from multiplier
// modport slave  : the arbiter side
// modport master : the requesters plus multiplier side
interface fp_mul_arbiter_if #(
  parameter int P = 32
);
  logic         req0_valid;
  logic         req1_valid;
  logic         req0_ready;
  logic         req1_ready;
  logic [P-1:0] req0_a;
  logic [P-1:0] req0_b;
  logic [P-1:0] req1_a;
  logic [P-1:0] req1_b;
  logic         res0_valid;
  logic         res1_valid;
  logic         res0_ready;
  logic         res1_ready;
  logic [P-1:0] res_data;
  logic [P-1:0] mul_a;
  logic [P-1:0] mul_b;
  logic [P-1:0] mul_p;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  res0_ready, res1_ready, mul_p,
    output req0_ready, req1_ready, res0_valid, res1_valid,
    output res_data, mul_a, mul_b
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output res0_ready, res1_ready, mul_p,
    input  req0_ready, req1_ready, res0_valid, res1_valid,
    input  res_data, mul_a, mul_b
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one combinational FP multiplier between two
// requesters. One operation in flight at a time: IDLE -> BUSY -> DONE.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fp_mul_arbiter_if.slave (request, result and multiplier signals)
// Product bits are passed through untouched; arithmetic belongs to the
// external multiplier.
module fp_mul_arbiter #(
  parameter int P = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_mul_arbiter_if.slave       bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   state_q,    state_d;
  logic         rr_q,       rr_d;
  logic         owner_q,    owner_d;
  logic [P-1:0] mul_a_q,    mul_a_d;
  logic [P-1:0] mul_b_q,    mul_b_d;
  logic [P-1:0] res_data_q, res_data_d;

  logic grant_id;
  logic grant0, grant1;
  logic owner_rdy;

  // With both valid the favoured id wins; otherwise whichever is valid.
  assign grant_id  = (bus.req0_valid && bus.req1_valid) ? rr_q : bus.req1_valid;
  assign owner_rdy = owner_q ? bus.res1_ready : bus.res0_ready;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    res_data_d = res_data_q;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          state_d = BUSY;
          owner_d = grant_id;
          rr_d    = ~grant_id;
          grant0  = ~grant_id;
          grant1  = grant_id;
          mul_a_d = grant_id ? bus.req1_a : bus.req0_a;
          mul_b_d = grant_id ? bus.req1_b : bus.req0_b;
        end
      end
      BUSY: begin
        res_data_d = bus.mul_p;
        state_d    = DONE;
      end
      DONE: begin
        if (owner_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      owner_q    <= 1'b0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      res_data_q <= res_data_d;
    end
  end

  // req_ready is combinational from req_valid; gating with rst_n keeps it
  // low while reset is held even though the state already reads IDLE.
  assign bus.req0_ready = grant0 & rst_n;
  assign bus.req1_ready = grant1 & rst_n;
  assign bus.res0_valid = (state_q == DONE) && !owner_q;
  assign bus.res1_valid = (state_q == DONE) &&  owner_q;
  assign bus.res_data   = res_data_q;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
module tb_fp_mul_arbiter;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  fp_mul_arbiter_if #(.P(32)) bus ();

  fp_mul_arbiter #(.P(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in multiplier: exact products for the directed operand pairs,
  // an arbitrary but deterministic mix for everything else.
  function automatic logic [31:0] mul_stub(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40100000;
    if (a == 32'hC0000000 && b == 32'h3F000000) return 32'hBF800000;
    return (a ^ {b[15:0], b[31:16]}) + 32'h9E3779B9;
  endfunction

  assign bus.mul_p = mul_stub(bus.mul_a, bus.mul_b);

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.res0_ready = 1'b0; bus.res1_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.req0_ready, bus.req1_ready, bus.res0_valid, bus.res1_valid} !== 4'b0) begin
      fails++; $display("FAIL reset_flags got %b exp 0000",
        {bus.req0_ready, bus.req1_ready, bus.res0_valid, bus.res1_valid});
    end
    tests++;
    if ({bus.res_data, bus.mul_a, bus.mul_b} !== 96'h0) begin
      fails++; $display("FAIL reset_data got %h %h %h exp 0", bus.res_data, bus.mul_a, bus.mul_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      fails++; $display("FAIL first_grant got %b exp 10", {bus.req0_ready, bus.req1_ready});
    end
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 32'h40000000; bus.req0_b = 32'h40400000;
    bus.res0_ready = 1'b1;
    #1;
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      fails++; $display("FAIL single_accept got %b exp 10", {bus.req0_ready, bus.req1_ready});
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    tests++;
    if ({bus.req0_ready, bus.res0_valid, bus.res1_valid, bus.mul_a, bus.mul_b} !== {3'b000, 32'h40000000, 32'h40400000}) begin
      fails++; $display("FAIL single_busy got %b %h %h exp 000 40000000 40400000",
        {bus.req0_ready, bus.res0_valid, bus.res1_valid}, bus.mul_a, bus.mul_b);
    end
    @(negedge clk);
    #1;
    tests++;
    if ({bus.res0_valid, bus.res1_valid, bus.res_data} !== {2'b10, 32'h40C00000}) begin
      fails++; $display("FAIL single_done got %b %h exp 10 40c00000",
        {bus.res0_valid, bus.res1_valid}, bus.res_data);
    end
    @(negedge clk);
    #1;
    tests++;
    if ({bus.res0_valid, bus.res1_valid} !== 2'b00) begin
      fails++; $display("FAIL single_release got %b exp 00", {bus.res0_valid, bus.res1_valid});
    end
    idle_inputs();
  endtask

  task automatic test_contention();
    logic exp_g;
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 32'h3FC00000; bus.req0_b = 32'h3FC00000;
    bus.req1_valid = 1'b1; bus.req1_a = 32'hC0000000; bus.req1_b = 32'h3F000000;
    bus.res0_ready = 1'b1; bus.res1_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      exp_g = op[0];
      #1;
      tests++;
      if ({bus.req0_ready, bus.req1_ready} !== {~exp_g, exp_g}) begin
        fails++; $display("FAIL contend_grant%0d got %b exp %b", op,
          {bus.req0_ready, bus.req1_ready}, {~exp_g, exp_g});
      end
      @(negedge clk);
      @(negedge clk);
      #1;
      tests++;
      if ({bus.res0_valid, bus.res1_valid, bus.res_data} !==
          {~exp_g, exp_g, (exp_g ? 32'hBF800000 : 32'h40100000)}) begin
        fails++; $display("FAIL contend_result%0d got %b %h exp %b %h", op,
          {bus.res0_valid, bus.res1_valid}, bus.res_data, {~exp_g, exp_g},
          (exp_g ? 32'hBF800000 : 32'h40100000));
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.req1_valid = 1'b1; bus.req1_a = 32'hC0000000; bus.req1_b = 32'h3F000000;
    #1;
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      fails++; $display("FAIL bp_grant1 got %b exp 01", {bus.req0_ready, bus.req1_ready});
    end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'h3FC00000; bus.req0_b = 32'h3FC00000;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      tests++;
      if ({bus.res1_valid, bus.res0_valid, bus.req0_ready, bus.res_data} !== {3'b100, 32'hBF800000}) begin
        fails++; $display("FAIL bp_hold%0d got %b %h exp 100 bf800000", i,
          {bus.res1_valid, bus.res0_valid, bus.req0_ready}, bus.res_data);
      end
      @(negedge clk);
    end
    bus.res1_ready = 1'b1;
    #1;
    tests++;
    if ({bus.res1_valid, bus.req0_ready} !== 2'b10) begin
      fails++; $display("FAIL bp_consume got %b exp 10", {bus.res1_valid, bus.req0_ready});
    end
    @(negedge clk);
    bus.res1_ready = 1'b0;
    #1;
    tests++;
    if ({bus.req0_ready, bus.res1_valid} !== 2'b10) begin
      fails++; $display("FAIL bp_next_grant got %b exp 10", {bus.req0_ready, bus.res1_valid});
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 32'h40000000; bus.req0_b = 32'h40400000;
    bus.res0_ready = 1'b1;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    tests++;
    if ({bus.req0_ready, bus.req1_ready, bus.res0_valid, bus.res1_valid,
         bus.res_data, bus.mul_a, bus.mul_b} !== 100'h0) begin
      fails++; $display("FAIL midreset_outputs got %b %h %h %h exp all 0",
        {bus.req0_ready, bus.req1_ready, bus.res0_valid, bus.res1_valid},
        bus.res_data, bus.mul_a, bus.mul_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if ({bus.res0_valid, bus.res1_valid} !== 2'b00) begin
        fails++; $display("FAIL midreset_no_result%0d got %b exp 00", i, {bus.res0_valid, bus.res1_valid});
      end
      @(negedge clk);
    end
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      fails++; $display("FAIL midreset_grant got %b exp 10", {bus.req0_ready, bus.req1_ready});
    end
    idle_inputs();
  endtask

  task automatic test_lone();
    do_reset();
    bus.req1_valid = 1'b1; bus.req1_a = 32'h12345678; bus.req1_b = 32'h9ABCDEF0;
    bus.res1_ready = 1'b1;
    #1;
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      fails++; $display("FAIL lone_grant got %b exp 01", {bus.req0_ready, bus.req1_ready});
    end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if ({bus.res1_valid, bus.res_data} !== {1'b1, mul_stub(32'h12345678, 32'h9ABCDEF0)}) begin
      fails++; $display("FAIL lone_result got %b %h exp 1 %h", bus.res1_valid, bus.res_data,
        mul_stub(32'h12345678, 32'h9ABCDEF0));
    end
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      fails++; $display("FAIL lone_rr_after got %b exp 10", {bus.req0_ready, bus.req1_ready});
    end
    idle_inputs();
  endtask

  task automatic test_wrong_owner();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 32'h40000000; bus.req0_b = 32'h40400000;
    bus.res1_ready = 1'b1;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if ({bus.res0_valid, bus.res1_valid, bus.res_data} !== {2'b10, 32'h40C00000}) begin
        fails++; $display("FAIL wrong_owner_hold%0d got %b %h exp 10 40c00000", i,
          {bus.res0_valid, bus.res1_valid}, bus.res_data);
      end
      @(negedge clk);
    end
    bus.res0_ready = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if ({bus.res0_valid, bus.res1_valid} !== 2'b00) begin
      fails++; $display("FAIL wrong_owner_release got %b exp 00", {bus.res0_valid, bus.res1_valid});
    end
    idle_inputs();
  endtask

  // Transaction-level model: an operation is accepted, its result shows up
  // two edges later and stays until its owner takes it.
  task automatic test_random(input int n);
    bit          m_busy;
    int          m_age;
    bit          m_owner;
    bit          m_rr;
    bit          g;
    bit          can_grant;
    logic [31:0] m_a, m_b, m_prod;
    logic [3:0]  exp_flags;
    bit          rdy;
    do_reset();
    m_busy = 0; m_age = 0; m_owner = 0; m_rr = 0;
    m_a = '0; m_b = '0; m_prod = '0;
    for (int c = 0; c < n; c++) begin
      bus.req0_valid = ($urandom_range(0, 2) != 0);
      bus.req1_valid = ($urandom_range(0, 2) != 0);
      bus.req0_a = $urandom(); bus.req0_b = $urandom();
      bus.req1_a = $urandom(); bus.req1_b = $urandom();
      bus.res0_ready = ($urandom_range(0, 3) != 0);
      bus.res1_ready = ($urandom_range(0, 3) != 0);
      #1;
      can_grant = !m_busy && (bus.req0_valid || bus.req1_valid);
      g = (bus.req0_valid && bus.req1_valid) ? m_rr : bus.req1_valid;
      exp_flags = {can_grant && !g, can_grant && g,
                   m_busy && m_age >= 2 && !m_owner, m_busy && m_age >= 2 && m_owner};
      tests++;
      if ({bus.req0_ready, bus.req1_ready, bus.res0_valid, bus.res1_valid} !== exp_flags) begin
        fails++; $display("FAIL rand_flags cyc%0d got %b exp %b", c,
          {bus.req0_ready, bus.req1_ready, bus.res0_valid, bus.res1_valid}, exp_flags);
      end
      if (m_busy) begin
        tests++;
        if ({bus.mul_a, bus.mul_b} !== {m_a, m_b}) begin
          fails++; $display("FAIL rand_operands cyc%0d got %h %h exp %h %h", c,
            bus.mul_a, bus.mul_b, m_a, m_b);
        end
      end
      if (m_busy && m_age >= 2) begin
        tests++;
        if (bus.res_data !== m_prod) begin
          fails++; $display("FAIL rand_data cyc%0d got %h exp %h", c, bus.res_data, m_prod);
        end
      end
      rdy = m_owner ? bus.res1_ready : bus.res0_ready;
      if (m_busy && m_age >= 2 && rdy) begin
        m_busy = 0;
      end else if (m_busy) begin
        m_age++;
      end else if (can_grant) begin
        m_busy = 1; m_age = 1; m_owner = g; m_rr = ~g;
        m_a = g ? bus.req1_a : bus.req0_a;
        m_b = g ? bus.req1_b : bus.req0_b;
        m_prod = mul_stub(m_a, m_b);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_lone();
    test_wrong_owner();
    test_random(400);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
